// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared sorter constants and serializer FSM state encoding
package sorter_pkg;

    localparam int DATA_WIDTH = 3;
    localparam int NUM_ELEMS  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/sort_order_checker.sv
// rtl/sort_order_checker.sv - sticky flag for any element smaller than its predecessor in a vector
module sort_order_checker
    import sorter_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  elem_hs,
    input  logic                  elem_first,
    input  logic [data_width-1:0] elem_data,
    output logic                  order_err
);

    logic [data_width-1:0] prev_q, prev_d;
    logic                  err_q, err_d;

    // The first element of each vector restarts the comparison chain, so
    // ordering is never checked across a vector boundary.
    always_comb begin
        prev_d = prev_q;
        err_d  = err_q;
        if (elem_hs) begin
            prev_d = elem_data;
            if (!elem_first && (elem_data < prev_q)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign order_err = err_q;

endmodule

// File: rtl/sorted_vec_serializer.sv
// rtl/sorted_vec_serializer.sv - streams a captured sorted vector one element per cycle
// Optional order checking is built when SORT_ORDER_CHECK_EN is defined.
module sorted_vec_serializer
    import sorter_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int num_elems  = NUM_ELEMS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [num_elems*data_width-1:0] in_vec,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [data_width-1:0]           out_data,
    output logic [$clog2(num_elems)-1:0]    out_idx,
    output logic                            out_first,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [15:0]                     vec_count,
    output logic                            order_err
);

    localparam int             IW       = $clog2(num_elems);
    localparam logic [IW-1:0]  LAST_IDX = IW'(num_elems - 1);

    state_e                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [num_elems*data_width-1:0] vec_q, vec_d;
    logic [15:0]                     cnt_q, cnt_d;

    logic emit;
    logic is_last;
    logic out_hs;
    logic in_hs;

    assign emit    = (state_q == EMIT);
    assign is_last = (idx_q == LAST_IDX);
    assign out_hs  = emit & out_ready;

    // Ready depends only on state and out_ready so a new vector can slip in
    // on the cycle the last element leaves, with no bubble.
    assign in_ready = rst_n & (~emit | (out_hs & is_last));
    assign in_hs    = in_valid & in_ready;

    assign out_valid = emit;
    assign out_first = emit & (idx_q == '0);
    assign out_last  = emit & is_last;
    assign out_idx   = idx_q;
    assign out_data  = emit ? vec_q[idx_q*data_width +: data_width] : '0;
    assign vec_count = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    vec_d   = in_vec;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_hs) begin
                    if (!is_last) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        idx_d = '0;
                        if (in_hs) begin
                            vec_d = in_vec;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SORT_ORDER_CHECK_EN
    sort_order_checker #(
        .data_width (data_width)
    ) u_order_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .elem_hs    (out_hs),
        .elem_first (out_first),
        .elem_data  (out_data),
        .order_err  (order_err)
    );
`else
    assign order_err = 1'b0;
`endif

endmodule
